// File: rtl/nx_fifo_rd_stage.sv
// -----------------------------------------------------------------------------
// nx_fifo_rd_stage
//
// Read-side stage behind an nx_fifo. It pops words through the FIFO's
// empty/ren/rdata interface and presents them on a registered valid/ready
// stream. A two-entry buffer (head + skid) keeps full throughput while the
// pop strobe depends only on local registered state and fifo_empty, never
// on out_ready. The word MSB is an end-of-packet flag; accepted words and
// packets are counted with saturating counters.
//
// Ports:
//   clk, rst_n   block clock, asynchronous active-low reset
//   fifo_empty   upstream FIFO empty flag
//   fifo_rdata   upstream FIFO read data (valid whenever fifo_empty=0)
//   fifo_ren     pop strobe to the upstream FIFO
//   out_valid    output word valid
//   out_ready    downstream accept
//   out_data     output word, eop in MSB
//   clear        synchronous flush of buffer and statistics
//   in_pkt       high between an accepted non-eop word and the next eop
//   word_cnt     accepted words (saturating)
//   pkt_cnt      accepted eop words (saturating)
// -----------------------------------------------------------------------------
module nx_fifo_rd_stage #(
    parameter int WIDTH = 65,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_ren,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             clear,
    output logic             in_pkt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] pkt_cnt
);

    // Buffer occupancy states
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       r_occ;
    logic [1:0]       w_occ_nxt;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_head_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             r_in_pkt;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_pkt_cnt;
    logic             w_pop;
    logic             w_acc;
    logic             w_head_eop;

    // The pop decision looks only at registered occupancy, so the FIFO read
    // path never sees out_ready. Gating with rst_n keeps the strobe low while
    // the block is held in reset.
    assign w_pop      = rst_n & ~fifo_empty & (r_occ != OCC_TWO) & ~clear;
    assign w_acc      = (r_occ != OCC_EMPTY) & out_ready & ~clear;
    assign w_head_eop = r_head[WIDTH-1];

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        w_occ_nxt  = r_occ;
        w_head_nxt = r_head;
        w_skid_nxt = r_skid;
        if (clear) begin
            w_occ_nxt = OCC_EMPTY;
        end else begin
            case (r_occ)
                OCC_EMPTY: begin
                    if (w_pop) begin
                        w_head_nxt = fifo_rdata;
                        w_occ_nxt  = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (w_pop && w_acc) begin
                        // Head leaves and the new word replaces it directly.
                        w_head_nxt = fifo_rdata;
                    end else if (w_pop) begin
                        w_skid_nxt = fifo_rdata;
                        w_occ_nxt  = OCC_TWO;
                    end else if (w_acc) begin
                        w_occ_nxt = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (w_acc) begin
                        w_head_nxt = r_skid;
                        w_occ_nxt  = OCC_ONE;
                    end
                end
                default: w_occ_nxt = OCC_EMPTY;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ  <= OCC_EMPTY;
            // NOTE: the two buffer entries are plain flops, not a RAM, so
            // they are reset to keep out_data at zero after reset.
            r_head <= '0;
            r_skid <= '0;
        end else begin
            r_occ  <= w_occ_nxt;
            r_head <= w_head_nxt;
            r_skid <= w_skid_nxt;
        end
    end

    // Statistics: counted on the word leaving the head, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= '0;
            r_pkt_cnt  <= '0;
            r_in_pkt   <= 1'b0;
        end else if (clear) begin
            r_word_cnt <= '0;
            r_pkt_cnt  <= '0;
            r_in_pkt   <= 1'b0;
        end else if (w_acc) begin
            if (r_word_cnt != CNT_MAX) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
            if (w_head_eop && (r_pkt_cnt != CNT_MAX)) begin
                r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
            end
            r_in_pkt <= ~w_head_eop;
        end
    end

    assign fifo_ren  = w_pop;
    assign out_valid = (r_occ != OCC_EMPTY);
    assign out_data  = r_head;
    assign in_pkt    = r_in_pkt;
    assign word_cnt  = r_word_cnt;
    assign pkt_cnt   = r_pkt_cnt;

endmodule

// File: doc/nx_fifo_rd_stage.md
Name: nx_fifo_rd_stage

Overview:
- Downstream consumer of an nx_fifo instance. Pops words through the FIFO's empty/ren/rdata interface and presents them on a registered valid/ready stream.
- A 2-entry output buffer gives full throughput. fifo_ren never depends combinationally on out_ready, which isolates timing between the FIFO and the downstream consumer.
- The MSB of each word is an end-of-packet flag. The block keeps word and packet statistics for status readout.

Parameters:
- WIDTH, 65, FIFO word width. Bit WIDTH-1 is eop; bits WIDTH-2:0 are payload.
- CNT_W, 32, width of the word and packet statistics counters.

Ports:
- clk  input  1  block clock
- rst_n  input  1  asynchronous active-low reset
- fifo_empty  input  1  upstream nx_fifo empty flag
- fifo_rdata  input  WIDTH  upstream nx_fifo read data. Valid in the same cycle whenever fifo_empty=0.
- fifo_ren  output  1  pop strobe to upstream nx_fifo
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accept
- out_data  output  WIDTH  output word, eop in MSB
- clear  input  1  synchronous flush of the buffer and statistics
- in_pkt  output  1  high between an accepted non-eop word and the next accepted eop word
- word_cnt  output  CNT_W  accepted words, saturating
- pkt_cnt  output  CNT_W  accepted eop words, saturating

Behaviour:
- Reset (rst_n=0, asynchronous):
  - occupancy=0; out_valid=0, out_data=0, fifo_ren=0, in_pkt=0, word_cnt=0, pkt_cnt=0.
  - Buffer entries are cleared to 0.
- Occupancy state machine (all transitions on posedge clk):
  - States: EMPTY(0), ONE(1), TWO(2).
  - acc = out_valid & out_ready.
  - next occupancy = occ + fifo_ren − acc.
  - EMPTY→ONE on pop. ONE→TWO on pop without acc. ONE→EMPTY on acc without pop. ONE stays ONE on pop with acc. TWO→ONE on acc. TWO never pops.
- Pop rule (combinational): fifo_ren = !fifo_empty & (occ<2) & !clear.
  - This depends only on registered state and fifo_empty, never on out_ready.
  - The popped word is captured from fifo_rdata at the same clock edge.
- Ordering and latency:
  - Entry 0 (head) drives out_data; entry 1 is the skid.
  - out_valid = (occ!=0), registered.
  - Latency is 1 cycle: a word present on fifo_rdata with fifo_ren=1 at edge N appears on out_data after edge N.
  - On acc with occ=2, the skid shifts into the head.
  - On simultaneous acc and pop with occ=1, the new word loads the head directly.
  - Words leave in strict FIFO order, with no duplication and no drop.
- Holding rule: while out_valid=1 and out_ready=0, out_data must stay stable.
- Throughput: with the FIFO continuously non-empty and out_ready=1, the block accepts one word per cycle after a 1-cycle fill.
- Statistics:
  - word_cnt increments on each acc.
  - pkt_cnt increments on each acc with out_data[WIDTH-1]=1.
  - Both counters saturate at all-ones and do not wrap.
  - in_pkt is set on acc of a non-eop word and cleared on acc of an eop word. A single-word packet (eop on first word) leaves in_pkt=0.
- clear (synchronous, one cycle):
  - Forces fifo_ren=0 in the same cycle. No acc is counted in that cycle.
  - Next state: occupancy=0, out_valid=0, in_pkt=0, counters=0.
  - Buffered words are discarded. Words still in the FIFO are not touched.
  - clear takes priority over pop and acc. The upstream FIFO has its own clear.
- Boundaries:
  - fifo_empty=1 with occ=0 → idle, out_valid=0.
  - out_ready high with out_valid=0 has no effect.
  - Reset mid-packet drops buffered data and zeros all state.
  - The block never generates a FIFO underflow: fifo_ren is never asserted while fifo_empty=1.

Test Plan:
- Streaming: FIFO preloaded with words 0x1..0x8, eop on 0x4 and 0x8; out_ready=1 constantly → out_data 0x1..0x8 on 8 consecutive cycles starting 1 cycle after the first pop; word_cnt=8, pkt_cnt=2, in_pkt=0.
- Backpressure: out_ready=0 for 5 cycles with FIFO non-empty → exactly 2 pops, then fifo_ren=0; out_data holds the first word stable; on release, order is preserved with no gaps.
- Random ready/empty: 1000 random words, 50% out_ready, 30% fifo_empty → scoreboard matches in order; fifo_ren never asserted with fifo_empty=1 or occ=2.
- Clear: occ=2, mid-packet, clear pulsed alongside out_ready=1 → next cycle out_valid=0, counters=0, in_pkt=0, no pop and no acc that cycle.
- Saturation with CNT_W=4: 20 eop words accepted → word_cnt=15, pkt_cnt=15, stable.
- Async reset: assert rst_n=0 between clock edges with occ=1 → out_valid drops immediately; after release, first FIFO word is popped 1 cycle later.
